fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the Control decoder.
- Holds the PC and fetches over a variable-latency instruction-memory handshake.
- Presents OpCode/Funct of the instruction in ID to Control.
- Takes Control's PCSrc/Branch back to redirect fetch for jumps, jr/jalr and taken beq, all resolved in ID with no delay slot.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. The PC is fetched over a
// variable-latency req/ready memory port, and fetch is redirected by jumps and branches resolved in ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        BranchEq,
    input  logic [31:0] JrTarget,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] PC
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetchState_t;

    fetchState_t stateReg, stateNext;
    logic [31:0] pcReg, pcNext;
    logic [31:0] instrReg, instrNext;
    logic [31:0] pcPlus4Reg, pcPlus4Next;
    logic        validReg, validNext;
    logic [31:0] skidReg, skidNext;
    logic [31:0] pendingReg, pendingNext;

    logic [31:0] seqPc;
    logic [31:0] branchOffset;
    logic [31:0] target;
    logic        redirect;

    assign seqPc        = pcReg + 32'd4;
    assign branchOffset = {{14{instrReg[15]}}, instrReg[15:0], 2'b00};

    // Redirect can only fire for a real instruction that is not being held.
    assign redirect = validReg & ~Stall & ((PCSrc != 2'b00) | (Branch & BranchEq));

    always_comb begin
        case (PCSrc)
            2'b01:   target = {pcPlus4Reg[31:28], instrReg[25:0], 2'b00};
            2'b10:   target = JrTarget;
            default: target = pcPlus4Reg + branchOffset;
        endcase
    end

    always_comb begin
        stateNext   = stateReg;
        pcNext      = pcReg;
        instrNext   = instrReg;
        pcPlus4Next = pcPlus4Reg;
        validNext   = validReg;
        skidNext    = skidReg;
        pendingNext = pendingReg;
        case (stateReg)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        validNext = 1'b0;
                        pcNext    = target;
                    end else if (Stall) begin
                        skidNext  = imem_rdata;
                        stateNext = HOLD;
                    end else begin
                        instrNext   = imem_rdata;
                        pcPlus4Next = seqPc;
                        validNext   = 1'b1;
                        pcNext      = seqPc;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the in-flight word returns.
                    pendingNext = target;
                    validNext   = 1'b0;
                    stateNext   = DISCARD;
                end else if (!Stall) begin
                    validNext = 1'b0;
                end
            end
            DISCARD: begin
                if (imem_ready) begin
                    pcNext    = pendingReg;
                    stateNext = FETCH;
                end
            end
            HOLD: begin
                if (!Stall) begin
                    stateNext = FETCH;
                    if (redirect) begin
                        validNext = 1'b0;
                        pcNext    = target;
                    end else begin
                        instrNext   = skidReg;
                        pcPlus4Next = seqPc;
                        validNext   = 1'b1;
                        pcNext      = seqPc;
                    end
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg   <= FETCH;
            pcReg      <= RESET_PC;
            instrReg   <= 32'h0;
            pcPlus4Reg <= 32'h0;
            validReg   <= 1'b0;
            skidReg    <= 32'h0;
            pendingReg <= 32'h0;
        end else begin
            stateReg   <= stateNext;
            pcReg      <= pcNext;
            instrReg   <= instrNext;
            pcPlus4Reg <= pcPlus4Next;
            validReg   <= validNext;
            skidReg    <= skidNext;
            pendingReg <= pendingNext;
        end
    end

    assign imem_req     = reset & (stateReg != HOLD);
    assign imem_addr    = pcReg;
    assign PC           = pcReg;
    assign IFID_Instr   = instrReg;
    assign IFID_PCPlus4 = pcPlus4Reg;
    assign IFID_Valid   = validReg;
    assign OpCode       = instrReg[31:26];
    assign Funct        = instrReg[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed phases push hand-computed fetch addresses and
// ID-slot contents; a monitor pops and compares whenever the DUT fetches or presents to ID.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        Stall;
    logic [1:0]  PCSrc;
    logic        Branch;
    logic        BranchEq;
    logic [31:0] JrTarget;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] PC;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .Stall(Stall), .PCSrc(PCSrc), .Branch(Branch), .BranchEq(BranchEq),
        .JrTarget(JrTarget), .OpCode(OpCode), .Funct(Funct),
        .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid), .PC(PC)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus4;
    } idExp_t;

    logic [31:0] expFetch[$];
    idExp_t      expId[$];
    int          errors = 0;
    int          checks = 0;
    int          image  = 0;

    // Memory images: 0 = data equals address; 1 = j loops; 2 = beq; 3 = jr.
    function automatic logic [31:0] memWord(input int img, input logic [31:0] addr);
        logic [31:0] w;
        w = addr;
        case (img)
            1: if (addr == 32'h0 || addr == 32'h0040_000C) w = 32'h0810_0003;
            2: begin
                if (addr == 32'h0)  w = 32'h0800_003F;
                if (addr == 32'hFC) w = 32'h1000_FFFE;
            end
            3: if (addr == 32'h0) w = 32'h03E0_0008;
            default: w = addr;
        endcase
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic pushId(input logic [31:0] instr, input logic [31:0] pc4);
        idExp_t e;
        e.instr   = instr;
        e.pcPlus4 = pc4;
        expId.push_back(e);
    endtask

    // One clock: drive memory and a small Control decode of the ID word at the negedge,
    // then return 2 time units later so callers can sample settled outputs.
    task automatic cyc(input logic rdy, input logic stl, input logic beq);
        @(negedge clk);
        imem_ready = rdy;
        Stall      = stl;
        BranchEq   = beq;
        imem_rdata = memWord(image, imem_addr);
        PCSrc      = 2'b00;
        Branch     = 1'b0;
        if (IFID_Instr[31:26] == 6'd2)
            PCSrc = 2'b01;
        else if (IFID_Instr[31:26] == 6'd0 && IFID_Instr[5:0] == 6'h08 && IFID_Instr[25:21] != 5'd0)
            PCSrc = 2'b10;
        if (IFID_Instr[31:26] == 6'd4)
            Branch = 1'b1;
        #2;
    endtask

    task automatic startPhase(input int img);
        image      = img;
        imem_ready = 1'b0;
        Stall      = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic endPhase(input string name);
        #1;
        reset      = 1'b0;
        imem_ready = 1'b0;
        Stall      = 1'b0;
        checks++;
        if (expFetch.size() != 0 || expId.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: fetch=%0d id=%0d required 0 0", name, expFetch.size(), expId.size());
        end else begin
            $display("ok   %s: all expected events seen", name);
        end
        expFetch.delete();
        expId.delete();
    endtask

    // Monitor: every accepted fetch and every instruction consumed by ID is scored.
    initial begin
        logic [31:0] ea;
        idExp_t      ei;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (imem_req && imem_ready) begin
                    if (expFetch.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch: got unexpected fetch of %h, required none", imem_addr);
                    end else begin
                        ea = expFetch.pop_front();
                        check("fetch addr", imem_addr, ea);
                    end
                end
                if (IFID_Valid && !Stall) begin
                    if (expId.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL id: got unexpected instr %h pc4 %h, required none", IFID_Instr, IFID_PCPlus4);
                    end else begin
                        ei = expId.pop_front();
                        check("id instr", IFID_Instr, ei.instr);
                        check("id pc+4", IFID_PCPlus4, ei.pcPlus4);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        Stall      = 1'b0;
        PCSrc      = 2'b00;
        Branch     = 1'b0;
        BranchEq   = 1'b0;
        JrTarget   = 32'h0000_2000;
        repeat (2) @(negedge clk);
        #2;
        check("reset PC", PC, 32'h0);
        check("reset IFID_Instr", IFID_Instr, 32'h0);
        check("reset IFID_PCPlus4", IFID_PCPlus4, 32'h0);
        check("reset IFID_Valid", 32'(IFID_Valid), 32'h0);
        check("reset imem_req", 32'(imem_req), 32'h0);

        // Zero-wait sequential fetch, data = address.
        startPhase(0);
        for (int i = 0; i < 4; i++) expFetch.push_back(32'(i * 4));
        for (int i = 0; i < 3; i++) pushId(32'(i * 4), 32'(i * 4 + 4));
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        endPhase("sequential");

        // j: 0 -> 0x40000C, then j at PC+4=0x400010 back to 0x40000C.
        startPhase(1);
        expFetch.push_back(32'h0);
        expFetch.push_back(32'h4);
        expFetch.push_back(32'h0040_000C);
        expFetch.push_back(32'h0040_0010);
        expFetch.push_back(32'h0040_000C);
        pushId(32'h0810_0003, 32'h4);
        pushId(32'h0810_0003, 32'h0040_0010);
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        check("j OpCode", 32'(OpCode), 32'd2);
        check("j Funct", 32'(Funct), 32'h03);
        cyc(1'b1, 1'b0, 1'b0);
        check("j bubble valid", 32'(IFID_Valid), 32'h0);
        check("j target addr", imem_addr, 32'h0040_000C);
        endPhase("jump");

        // beq at 0xFC (PC+4=0x100), imm -2: taken -> 0xF8, then not taken -> 0x100.
        startPhase(2);
        expFetch.push_back(32'h0);
        expFetch.push_back(32'h4);
        expFetch.push_back(32'hFC);
        expFetch.push_back(32'h100);
        expFetch.push_back(32'hF8);
        expFetch.push_back(32'hFC);
        expFetch.push_back(32'h100);
        expFetch.push_back(32'h104);
        pushId(32'h0800_003F, 32'h4);
        pushId(32'h1000_FFFE, 32'h100);
        pushId(32'hF8, 32'hFC);
        pushId(32'h1000_FFFE, 32'h100);
        pushId(32'h100, 32'h104);
        repeat (5) cyc(1'b1, 1'b0, 1'b1);
        check("beq taken addr", imem_addr, 32'hF8);
        check("beq taken bubble", 32'(IFID_Valid), 32'h0);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        check("beq not-taken no bubble", 32'(IFID_Valid), 32'h1);
        endPhase("branch");

        // Stall for 3 cycles while ready arrives: word parked, then released once.
        startPhase(0);
        expFetch.push_back(32'h0);
        expFetch.push_back(32'h4);
        expFetch.push_back(32'h8);
        expFetch.push_back(32'hC);
        pushId(32'h0, 32'h4);
        pushId(32'h4, 32'h8);
        pushId(32'h8, 32'hC);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("hold imem_req", 32'(imem_req), 32'h0);
        check("hold PC", PC, 32'h8);
        check("hold IFID_Instr", IFID_Instr, 32'h4);
        cyc(1'b0, 1'b1, 1'b0);
        check("hold PC 2", PC, 32'h8);
        check("hold IFID_PCPlus4", IFID_PCPlus4, 32'h8);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("release PC", PC, 32'hC);
        endPhase("stall");

        // jr to 0x2000 while the next fetch takes 2 extra cycles: stale word dropped.
        startPhase(3);
        expFetch.push_back(32'h0);
        expFetch.push_back(32'h4);
        expFetch.push_back(32'h2000);
        expFetch.push_back(32'h2004);
        pushId(32'h03E0_0008, 32'h4);
        pushId(32'h2000, 32'h2004);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("discard imem_req", 32'(imem_req), 32'h1);
        check("discard held addr", imem_addr, 32'h4);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("jr target addr", imem_addr, 32'h2000);
        cyc(1'b1, 1'b0, 1'b0);
        endPhase("jr");

        // Asynchronous reset while waiting on memory.
        startPhase(0);
        expFetch.push_back(32'h0);
        expFetch.push_back(32'h4);
        pushId(32'h0, 32'h4);
        pushId(32'h4, 32'h8);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("pre-reset PC", PC, 32'h8);
        #1;
        reset = 1'b0;
        #1;
        check("async reset PC", PC, 32'h0);
        check("async reset IFID_Instr", IFID_Instr, 32'h0);
        check("async reset IFID_PCPlus4", IFID_PCPlus4, 32'h0);
        check("async reset IFID_Valid", 32'(IFID_Valid), 32'h0);
        check("async reset imem_req", 32'(imem_req), 32'h0);
        endPhase("async reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
